// File: rtl/mac_sequencer.sv
// Load/run sequencer for the shared RAM/ROM multiply-accumulate datapath.
// Define MAC_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module mac_sequencer #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 4,
   parameter int unsigned ACC_W  = 12,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              CLOCK_50,
   input  logic              rst,
   input  logic              rx_dv,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              start,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [ADDR_W-1:0] mem_raddr,
   input  logic [DATA_W-1:0] ram_rdata,
   input  logic [DATA_W-1:0] rom_rdata,
   output logic [ADDR_W-1:0] count_w,
   output logic [ADDR_W-1:0] count_r,
   output logic              load_full,
   output logic              busy,
   output logic              done,
   output logic [ACC_W-1:0]  acc,
   output logic              acc_ovf
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned DCW = $clog2(RD_LAT) + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [DCW-1:0] DRAIN_LAST = DCW'(RD_LAT - 1);

   typedef enum logic [2:0] {StLoad, StSetup, StRun, StDrain, StDone} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   count_w_q, count_w_d;
   logic                load_full_q, load_full_d;
   logic [ADDR_W-1:0]   count_r_q, count_r_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic                acc_ovf_q, acc_ovf_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [RD_LAT-1:0]   vld_q, vld_d;
   logic [DCW-1:0]      drain_cnt_q, drain_cnt_d;

   logic [2*DATA_W-1:0] prod;
   logic [ACC_W:0]      sum;
   logic                in_flight;

   always_comb begin
      prod = {{DATA_W{1'b0}}, ram_rdata} * {{DATA_W{1'b0}}, rom_rdata};
      sum  = {1'b0, acc_q} + (ACC_W + 1)'(prod);
   end

   assign in_flight = (state_q == StSetup) || (state_q == StRun) || (state_q == StDrain);

   always_comb begin
      state_d     = state_q;
      count_w_d   = count_w_q;
      load_full_d = load_full_q;
      count_r_d   = count_r_q;
      acc_d       = acc_q;
      acc_ovf_d   = acc_ovf_q;
      we_d        = 1'b0;
      waddr_d     = waddr_q;
      wdata_d     = wdata_q;
      drain_cnt_d = '0;
      // Read-valid pipeline: bit RD_LAT-1 marks the cycle rdata of an issued address arrives.
      vld_d       = (vld_q << 1) | RD_LAT'(state_q == StRun);

      if (vld_q[RD_LAT-1]) begin
         if (sum[ACC_W]) begin
            acc_ovf_d = 1'b1;
`ifdef MAC_SAT_EN
            acc_d = '1;
`else
            acc_d = sum[ACC_W-1:0];
`endif
         end else begin
            acc_d = sum[ACC_W-1:0];
         end
      end

      unique case (state_q)
         StLoad: begin
            if (rx_dv && !load_full_q) begin
               we_d    = 1'b1;
               waddr_d = count_w_q;
               wdata_d = rx_data;
               if (count_w_q == LAST_ADDR) begin
                  load_full_d = 1'b1;
               end else begin
                  count_w_d = count_w_q + 1'b1;
               end
            end
            if (start) begin
               state_d   = StSetup;
               acc_d     = '0;
               acc_ovf_d = 1'b0;
               count_r_d = '0;
            end
         end
         StSetup: state_d = StRun;
         StRun: begin
            if (count_r_q == LAST_ADDR) begin
               state_d = StDrain;
            end else begin
               count_r_d = count_r_q + 1'b1;
            end
         end
         StDrain: begin
            drain_cnt_d = drain_cnt_q + 1'b1;
            if (drain_cnt_q == DRAIN_LAST) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (!start) begin
               state_d     = StLoad;
               count_w_d   = '0;
               load_full_d = 1'b0;
            end
         end
         default: state_d = StLoad;
      endcase

      // Dropping start mid-computation abandons the result.
      if (in_flight && !start) begin
         state_d   = StLoad;
         acc_d     = '0;
         acc_ovf_d = 1'b0;
         vld_d     = '0;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         state_q     <= StLoad;
         count_w_q   <= '0;
         load_full_q <= 1'b0;
         count_r_q   <= '0;
         acc_q       <= '0;
         acc_ovf_q   <= 1'b0;
         we_q        <= 1'b0;
         waddr_q     <= '0;
         wdata_q     <= '0;
         vld_q       <= '0;
         drain_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         count_w_q   <= count_w_d;
         load_full_q <= load_full_d;
         count_r_q   <= count_r_d;
         acc_q       <= acc_d;
         acc_ovf_q   <= acc_ovf_d;
         we_q        <= we_d;
         waddr_q     <= waddr_d;
         wdata_q     <= wdata_d;
         vld_q       <= vld_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

   assign mem_we    = we_q;
   assign mem_waddr = waddr_q;
   assign mem_wdata = wdata_q;
   assign mem_raddr = (state_q == StRun) ? count_r_q : '0;
   assign count_w   = count_w_q;
   assign count_r   = count_r_q;
   assign load_full = load_full_q;
   assign busy      = in_flight;
   assign done      = (state_q == StDone);
   assign acc       = acc_q;
   assign acc_ovf   = acc_ovf_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed bench for mac_sequencer: RAM/ROM models, write scoreboard, result checks.
// A second instance with ACC_W=8 exercises overflow (wrap or MAC_SAT_EN clamp).
module tb_mac_sequencer;

   localparam bit Sat =
`ifdef MAC_SAT_EN
      1'b1;
`else
      1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, rx_dv, start;
   logic [3:0] rx_data;
   logic       mem_we, load_full, busy, done, acc_ovf;
   logic [3:0] mem_waddr, mem_wdata, mem_raddr, count_w, count_r;
   logic [3:0] ram_rdata, rom_rdata;
   logic [11:0] acc;
   logic       mem_we8, load_full8, busy8, done8, acc_ovf8;
   logic [3:0] mem_waddr8, mem_wdata8, mem_raddr8, count_w8, count_r8;
   logic [7:0] acc8;

   logic [3:0] ram [16];
   logic [3:0] rom [16];
   logic [3:0] exp_ram [16];
   logic       fill_req;
   logic [3:0] fill_val;
   logic [7:0] wr_q [$];
   int         tests = 0;
   int         fails = 0;
   int         wcnt;
   int         lat;

   always #5 clk = ~clk;

   mac_sequencer #(.ADDR_W(4), .DATA_W(4), .ACC_W(12), .RD_LAT(1)) dut (
      .CLOCK_50(clk), .rst(rst), .rx_dv(rx_dv), .rx_data(rx_data), .start(start),
      .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_raddr(mem_raddr),
      .ram_rdata(ram_rdata), .rom_rdata(rom_rdata), .count_w(count_w), .count_r(count_r),
      .load_full(load_full), .busy(busy), .done(done), .acc(acc), .acc_ovf(acc_ovf)
   );

   mac_sequencer #(.ADDR_W(4), .DATA_W(4), .ACC_W(8), .RD_LAT(1)) dut8 (
      .CLOCK_50(clk), .rst(rst), .rx_dv(rx_dv), .rx_data(rx_data), .start(start),
      .mem_we(mem_we8), .mem_waddr(mem_waddr8), .mem_wdata(mem_wdata8),
      .mem_raddr(mem_raddr8), .ram_rdata(ram_rdata), .rom_rdata(rom_rdata),
      .count_w(count_w8), .count_r(count_r8), .load_full(load_full8), .busy(busy8),
      .done(done8), .acc(acc8), .acc_ovf(acc_ovf8)
   );

   // Synchronous-read memories, one cycle raddr -> rdata.
   always @(posedge clk) begin
      if (fill_req) begin
         for (int i = 0; i < 16; i++) ram[i] <= fill_val;
      end else if (mem_we) begin
         ram[mem_waddr] <= mem_wdata;
      end
      ram_rdata <= ram[mem_raddr];
      rom_rdata <= rom[mem_raddr];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, then score any RAM write against the queue.
   task automatic tick();
      logic [7:0] e;
      @(posedge clk);
      #1;
      if (mem_we) begin
         e = 'x;
         if (wr_q.size() != 0) e = wr_q.pop_front();
         check("write", 32'({mem_waddr, mem_wdata}), 32'(e));
      end
   endtask

   task automatic send(input logic [3:0] d, input bit in_load);
      if (in_load && wcnt < 16) begin
         wr_q.push_back({4'(wcnt), d});
         exp_ram[wcnt] = d;
         wcnt++;
      end
      rx_data = d;
      rx_dv = 1'b1;
      tick();
      rx_dv = 1'b0;
   endtask

   task automatic fill(input logic [3:0] v);
      fill_val = v;
      fill_req = 1'b1;
      tick();
      fill_req = 1'b0;
      for (int i = 0; i < 16; i++) exp_ram[i] = v;
   endtask

   task automatic wait_done(input int lat0, output int n);
      n = lat0;
      do begin
         tick();
         rx_dv = 1'b0;
         n++;
      end while (!done && n < 60);
   endtask

   function automatic int exp_sum();
      int s = 0;
      for (int i = 0; i < 16; i++) s += int'(exp_ram[i]) * int'(rom[i]);
      return s;
   endfunction

   function automatic logic [31:0] exp_acc8(input int s);
      if (s < 256) return 32'(s);
      return Sat ? 32'd255 : 32'(s % 256);
   endfunction

   task automatic check_result(input string tag);
      int s;
      s = exp_sum();
      check({tag, "_latency"}, 32'(lat), 32'd19);
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_acc"}, 32'(acc), 32'(s));
      check({tag, "_ovf"}, 32'(acc_ovf), 32'(s >= 4096));
      check({tag, "_count_r"}, 32'(count_r), 32'd15);
      check({tag, "_acc8"}, 32'(acc8), exp_acc8(s));
      check({tag, "_ovf8"}, 32'(acc_ovf8), 32'(s >= 256));
   endtask

   initial begin
      rst = 1'b1; rx_dv = 1'b0; rx_data = '0; start = 1'b0;
      fill_req = 1'b0; fill_val = '0; wcnt = 0; lat = 0;
      for (int i = 0; i < 16; i++) begin
         rom[i] = '0;
         exp_ram[i] = '0;
      end
      tick();
      fill(4'h0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_acc", 32'(acc), 32'd0);
      check("rst_count_w", 32'(count_w), 32'd0);
      check("rst_load_full", 32'(load_full), 32'd0);
      check("rst_raddr", 32'(mem_raddr), 32'd0);
      rst = 1'b0;

      // All-0xF load and run; 17th nibble must be dropped.
      for (int i = 0; i < 16; i++) rom[i] = 4'hF;
      for (int i = 0; i < 16; i++) send(4'hF, 1'b1);
      check("full_count_w", 32'(count_w), 32'd15);
      check("full_load_full", 32'(load_full), 32'd1);
      send(4'h7, 1'b1);
      check("extra_count_w", 32'(count_w), 32'd15);
      start = 1'b1;
      wait_done(0, lat);
      check_result("t1");
      check("t1_acc_value", 32'(acc), 32'hE10);
      check("t1_busy", 32'(busy), 32'd0);
      send(4'h3, 1'b0);
      start = 1'b0;
      tick();
      wcnt = 0;
      check("reload_done", 32'(done), 32'd0);
      check("reload_count_w", 32'(count_w), 32'd0);
      check("reload_load_full", 32'(load_full), 32'd0);
      check("reload_acc_held", 32'(acc), 32'hE10);

      // Partial load with a ramp ROM.
      fill(4'h0);
      for (int i = 0; i < 16; i++) rom[i] = 4'(i + 1);
      send(4'h1, 1'b1);
      send(4'h2, 1'b1);
      send(4'h3, 1'b1);
      check("t2_count_w", 32'(count_w), 32'd3);
      start = 1'b1;
      wait_done(0, lat);
      check_result("t2");
      check("t2_acc_value", 32'(acc), 32'd14);
      start = 1'b0;
      tick();
      wcnt = 0;

      // Nibble and start in the same cycle; write lands during SETUP.
      fill(4'h0);
      rom[0] = 4'h2;
      wr_q.push_back({4'h0, 4'h5});
      exp_ram[0] = 4'h5;
      wcnt = 1;
      rx_data = 4'h5;
      rx_dv = 1'b1;
      start = 1'b1;
      tick();
      rx_dv = 1'b0;
      check("t4_setup_busy", 32'(busy), 32'd1);
      check("t4_setup_acc", 32'(acc), 32'd0);
      wait_done(1, lat);
      check_result("t4");
      check("t4_acc_value", 32'(acc), 32'd10);
      start = 1'b0;
      tick();
      wcnt = 0;

      // Abort in RUN cycle 6, then a full rerun.
      fill(4'hF);
      for (int i = 0; i < 16; i++) rom[i] = 4'hF;
      start = 1'b1;
      tick();
      tick();
      repeat (6) tick();
      check("t5_count_r", 32'(count_r), 32'd6);
      start = 1'b0;
      tick();
      check("t5_abort_busy", 32'(busy), 32'd0);
      check("t5_abort_done", 32'(done), 32'd0);
      check("t5_abort_acc", 32'(acc), 32'd0);
      check("t5_abort_acc8", 32'(acc8), 32'd0);
      start = 1'b1;
      wait_done(0, lat);
      check_result("t5");
      start = 1'b0;
      tick();

      // Reset in the middle of RUN.
      start = 1'b1;
      repeat (5) tick();
      check("t6_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_acc", 32'(acc), 32'd0);
      check("t6_rst_ovf8", 32'(acc_ovf8), 32'd0);
      check("t6_rst_count_r", 32'(count_r), 32'd0);
      check("t6_rst_raddr", 32'(mem_raddr), 32'd0);
      rst = 1'b0;
      start = 1'b0;
      tick();

      check("writes_pending", 32'(wr_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
